// File: rtl/keyboard_note_if.sv
// Note interface between the PS/2 byte receiver, the note encoder and the
// display/tone consumers. The encoder side drives the 16-bit delay value,
// the note index and the change strobe. It receives scan-code bytes.
interface keyboard_note_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] delay;
    logic [4:0]  note_index;
    logic        note_changed;

    // encoder side: consumes scan-code bytes, produces the note
    modport master (
        input  rx_data,
        input  rx_valid,
        output delay,
        output note_index,
        output note_changed
    );

    // receiver / consumer side
    modport slave (
        output rx_data,
        output rx_valid,
        input  delay,
        input  note_index,
        input  note_changed
    );
endinterface

// File: rtl/keyboard_note_encoder.sv
// Turns PS/2 Set-2 scan-code bytes into the currently sounding note.
// It tracks the F0 (break) and E0 (extended) prefixes.
// The last-pressed mapped key wins. Releasing that key silences the output.
// A prefix left waiting too long is abandoned so that a lost byte cannot wedge the decoder.
module keyboard_note_encoder #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic               clk,
    input  logic               reset,
    keyboard_note_if.master    note_bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0]  CODE_BREAK = 8'hF0;
    localparam logic [7:0]  CODE_EXT   = 8'hE0;
    localparam logic [4:0]  NO_NOTE    = 5'd31;

    // Scan code -> {hit, note index, half-period delay}; misses return the "no note" pair.
    function automatic logic [21:0] key_lookup(input logic [7:0] code);
        logic [21:0] res;
        case (code)
            8'h1A:   res = {1'b1, 5'd0,  16'd23889};
            8'h1B:   res = {1'b1, 5'd1,  16'd22548};
            8'h22:   res = {1'b1, 5'd2,  16'd21283};
            8'h23:   res = {1'b1, 5'd3,  16'd20088};
            8'h21:   res = {1'b1, 5'd4,  16'd18961};
            8'h2A:   res = {1'b1, 5'd5,  16'd17897};
            8'h34:   res = {1'b1, 5'd6,  16'd16892};
            8'h3A:   res = {1'b1, 5'd7,  16'd15944};
            8'h3B:   res = {1'b1, 5'd8,  16'd15049};
            8'h41:   res = {1'b1, 5'd9,  16'd14205};
            8'h42:   res = {1'b1, 5'd10, 16'd13407};
            8'h49:   res = {1'b1, 5'd11, 16'd12655};
            8'h15:   res = {1'b1, 5'd12, 16'd47778};
            8'h1E:   res = {1'b1, 5'd13, 16'd45096};
            8'h1D:   res = {1'b1, 5'd14, 16'd42566};
            8'h26:   res = {1'b1, 5'd15, 16'd40176};
            8'h24:   res = {1'b1, 5'd16, 16'd37922};
            8'h2D:   res = {1'b1, 5'd17, 16'd35794};
            8'h2E:   res = {1'b1, 5'd18, 16'd33784};
            8'h3C:   res = {1'b1, 5'd19, 16'd31888};
            8'h3D:   res = {1'b1, 5'd20, 16'd30098};
            8'h43:   res = {1'b1, 5'd21, 16'd28410};
            8'h3E:   res = {1'b1, 5'd22, 16'd26814};
            8'h44:   res = {1'b1, 5'd23, 16'd25310};
            default: res = {1'b0, 5'd31, 16'd0};
        endcase
        return res;
    endfunction

    state_t            state_r, state_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic [15:0]       delay_r, delay_next_s;
    logic [4:0]        index_r, index_next_s;
    logic              changed_r, changed_next_s;

    logic [21:0]       key_s;
    logic              key_hit_s;
    logic [4:0]        key_index_s;
    logic [15:0]       key_delay_s;

    assign key_s       = key_lookup(note_bus.rx_data);
    assign key_hit_s   = key_s[21];
    assign key_index_s = key_s[20:16];
    assign key_delay_s = key_s[15:0];

    // Decide the next prefix state, timeout count and note from this cycle's byte.
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        delay_next_s   = delay_r;
        index_next_s   = index_r;
        changed_next_s = 1'b0;
        if (note_bus.rx_valid) begin
            // a byte always wins over a timeout expiring in the same cycle
            cnt_next_s = '0;
            case (state_r)
                IDLE: begin
                    if (note_bus.rx_data == CODE_BREAK) begin
                        state_next_s = BRK;
                    end else if (note_bus.rx_data == CODE_EXT) begin
                        state_next_s = EXT;
                    end else if (key_hit_s && (key_index_s != index_r)) begin
                        // new mapped key; a typematic repeat of the current key matches and is skipped
                        delay_next_s   = key_delay_s;
                        index_next_s   = key_index_s;
                        changed_next_s = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                BRK: begin
                    state_next_s = IDLE;
                    if (key_hit_s && (key_index_s == index_r)) begin
                        delay_next_s   = 16'd0;
                        index_next_s   = NO_NOTE;
                        changed_next_s = 1'b1;
                    end else begin
                        changed_next_s = 1'b0;
                    end
                end
                EXT: begin
                    if (note_bus.rx_data == CODE_BREAK) begin
                        state_next_s = EXT_BRK;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                EXT_BRK: state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end else begin
            case (state_r)
                IDLE: cnt_next_s = '0;
                BRK, EXT, EXT_BRK: begin
                    if (cnt_r == CNT_LAST) begin
                        state_next_s = IDLE;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s = cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end
    end

    // State, timeout counter and registered note outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            delay_r   <= 16'd0;
            index_r   <= NO_NOTE;
            changed_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            delay_r   <= delay_next_s;
            index_r   <= index_next_s;
            changed_r <= changed_next_s;
        end
    end

    assign note_bus.delay        = delay_r;
    assign note_bus.note_index   = index_r;
    assign note_bus.note_changed = changed_r;

endmodule

// File: tb/tb_keyboard_note_encoder.sv
// Bench for keyboard_note_encoder. It runs directed scenarios and then random byte traffic.
// Every cycle is compared against a key-tracking reference model.
module tb_keyboard_note_encoder;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset;

    keyboard_note_if bus ();

    keyboard_note_encoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .note_bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  key_code  [24] = '{8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2A, 8'h34, 8'h3A,
                                    8'h3B, 8'h41, 8'h42, 8'h49, 8'h15, 8'h1E, 8'h1D, 8'h26,
                                    8'h24, 8'h2D, 8'h2E, 8'h3C, 8'h3D, 8'h43, 8'h3E, 8'h44};
    int unsigned key_delay [24] = '{23889, 22548, 21283, 20088, 18961, 17897, 16892, 15944,
                                    15049, 14205, 13407, 12655, 47778, 45096, 42566, 40176,
                                    37922, 35794, 33784, 31888, 30098, 28410, 26814, 25310};

    int n_checks = 0;
    int n_bad    = 0;

    // reference model state: held note, pending prefixes, quiet cycles while a prefix waits
    int          cur = -1;
    bit          pend_f0 = 1'b0;
    bit          pend_e0 = 1'b0;
    int          quiet = 0;
    int unsigned m_delay = 0;
    int unsigned m_index = 31;
    int unsigned m_changed = 0;

    bit count_pulses = 1'b0;
    int pulses = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_key(input logic [7:0] b);
        int idx;
        idx = -1;
        for (int i = 0; i < 24; i++) begin
            if (key_code[i] == b) idx = i;
        end
        return idx;
    endfunction

    task automatic model_step(input logic rst, input logic v, input logic [7:0] b);
        int unsigned old;
        int k;
        old = m_delay;
        k = find_key(b);
        if (rst) begin
            cur = -1; pend_f0 = 1'b0; pend_e0 = 1'b0; quiet = 0;
        end else if (v) begin
            quiet = 0;
            if (pend_e0 && pend_f0) begin
                pend_e0 = 1'b0; pend_f0 = 1'b0;
            end else if (pend_e0) begin
                if (b == 8'hF0) pend_f0 = 1'b1;
                else pend_e0 = 1'b0;
            end else if (pend_f0) begin
                if (k >= 0 && k == cur) cur = -1;
                pend_f0 = 1'b0;
            end else if (b == 8'hF0) begin
                pend_f0 = 1'b1;
            end else if (b == 8'hE0) begin
                pend_e0 = 1'b1;
            end else if (k >= 0) begin
                cur = k;
            end
        end else if (pend_f0 || pend_e0) begin
            quiet++;
            if (quiet == TMO) begin
                pend_f0 = 1'b0; pend_e0 = 1'b0; quiet = 0;
            end
        end
        m_delay   = (cur < 0) ? 0 : key_delay[cur];
        m_index   = (cur < 0) ? 31 : cur;
        m_changed = (!rst && m_delay != old) ? 1 : 0;
    endtask

    // one clock: compare the outputs of the previous cycle's inputs, then drive new inputs
    task automatic cycle(input logic rst, input logic v, input logic [7:0] b);
        @(negedge clk);
        check_value("delay",   32'(bus.delay),        32'(m_delay));
        check_value("index",   32'(bus.note_index),   32'(m_index));
        check_value("changed", 32'(bus.note_changed), 32'(m_changed));
        if (count_pulses && bus.note_changed) pulses++;
        reset        = rst;
        bus.rx_valid = v;
        bus.rx_data  = b;
        model_step(rst, v, b);
    endtask

    task automatic send(input logic [7:0] b);
        cycle(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        idle(1);

        // first press and typematic repeats
        send(8'h1A); idle(1);
        check_value("t1_delay",   32'(bus.delay),        32'd23889);
        check_value("t1_index",   32'(bus.note_index),   32'd0);
        check_value("t1_changed", 32'(bus.note_changed), 32'd1);
        send(8'h1A); send(8'h1A); send(8'h1A); idle(2);

        // last pressed wins; releasing a non-current key has no effect
        send(8'h1A); send(8'h15); send(8'hF0); send(8'h1A); idle(1);
        check_value("t2_delay", 32'(bus.delay),      32'd47778);
        check_value("t2_index", 32'(bus.note_index), 32'd12);
        send(8'hF0); send(8'h15); idle(1);
        check_value("t2_rel_delay",   32'(bus.delay),        32'd0);
        check_value("t2_rel_index",   32'(bus.note_index),   32'd31);
        check_value("t2_rel_changed", 32'(bus.note_changed), 32'd1);
        idle(1);

        // extended and unmapped keys are ignored
        send(8'hE0); send(8'h1A); send(8'h1C); idle(1);
        check_value("t3_delay", 32'(bus.delay),      32'd0);
        check_value("t3_index", 32'(bus.note_index), 32'd31);
        send(8'h49); idle(1);
        check_value("t3_49_delay", 32'(bus.delay),      32'd12655);
        check_value("t3_49_index", 32'(bus.note_index), 32'd11);

        // prefix timeout boundary: gap one short of the limit still completes the break
        send(8'hF0); idle(TMO - 1); send(8'h22); idle(1);
        check_value("t4_short_gap", 32'(bus.delay), 32'd12655);
        send(8'hF0); idle(TMO); send(8'h22); idle(1);
        check_value("t4_full_gap", 32'(bus.delay), 32'd21283);

        // reset mid-sequence; a byte during reset is ignored
        send(8'h44); send(8'hF0); cycle(1'b1, 1'b1, 8'h1A); idle(1);
        check_value("t5_rst_delay", 32'(bus.delay),      32'd0);
        check_value("t5_rst_index", 32'(bus.note_index), 32'd31);
        send(8'h44); idle(1);
        check_value("t5_delay", 32'(bus.delay),      32'd25310);
        check_value("t5_index", 32'(bus.note_index), 32'd23);
        send(8'hF0); send(8'h44); idle(2);

        // back-to-back sweep of every mapped key
        pulses = 0;
        count_pulses = 1'b1;
        for (int i = 0; i < 24; i++) send(key_code[i]);
        idle(1);
        count_pulses = 1'b0;
        check_value("sweep_pulses", 32'(pulses), 32'd24);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            r = $urandom_range(0, 19);
            if (r < 8)       send(key_code[$urandom_range(0, 23)]);
            else if (r < 11) send(8'hF0);
            else if (r < 13) send(8'hE0);
            else if (r < 14) send(8'($urandom));
            else if (r < 15) idle($urandom_range(TMO - 2, TMO + 2));
            else if (r < 16) cycle(1'b1, $urandom_range(0, 1) == 1, key_code[$urandom_range(0, 23)]);
            else             idle(1);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
